// File: rtl/ss_dfifo_if.sv
// ss_dfifo bus bundle: ss_sgr segment/beat/flow-control signals plus consumer pop side.
// Statistic ports exist only when SS_DFIFO_STAT_EN is defined.
interface ss_dfifo_if #(parameter int unsigned AW = 4);
    logic          ss_xfer;
    logic [15:0]   sg_desc;
    logic          sg_last;
    logic          wbs_ack;
    logic [31:0]   wbs_dat_i;
    logic [31:0]   wbs_dat64_i;
    logic          ss_ready;
    logic          ss_done;
    logic          ss_rd_i;
    logic [63:0]   ss_q_o;
    logic          ss_empty_o;
    logic [AW:0]   ss_cnt_o;
    logic          ss_ovf_o;
`ifdef SS_DFIFO_STAT_EN
    logic [31:0]   ss_beats_o;
    logic [15:0]   ss_jobs_o;
`endif

    modport slave (
        input  ss_xfer, sg_desc, sg_last, wbs_ack, wbs_dat_i, wbs_dat64_i, ss_rd_i,
        output ss_ready, ss_done, ss_q_o, ss_empty_o, ss_cnt_o, ss_ovf_o
`ifdef SS_DFIFO_STAT_EN
        , output ss_beats_o, ss_jobs_o
`endif
    );

    modport master (
        output ss_xfer, sg_desc, sg_last, wbs_ack, wbs_dat_i, wbs_dat64_i, ss_rd_i,
        input  ss_ready, ss_done, ss_q_o, ss_empty_o, ss_cnt_o, ss_ovf_o
`ifdef SS_DFIFO_STAT_EN
        , input ss_beats_o, ss_jobs_o
`endif
    );
endinterface

// File: rtl/ss_dfifo.sv
// Data-side FWFT sink for ss_sgr: captures Wishbone beats per segment, tracks job end.
// Optional beat/job statistics outputs when SS_DFIFO_STAT_EN is defined.
module ss_dfifo #(
    parameter int unsigned AW    = 4,
    parameter int unsigned BURST = 4
) (
    input  logic      wb_clk_i,
    input  logic      wb_rst_ni,
    ss_dfifo_if.slave ss
);
    localparam int unsigned DEPTH = 2**AW;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned BW    = 14;

    typedef enum logic [2:0] {ST_IDLE, ST_XFER, ST_SEGEND, ST_DRAIN, ST_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_xfer_q, r_last;
    logic [BW-1:0]   r_target, r_beat_cnt, w_beat_cnt_nxt, w_target;
    logic [63:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_empty, r_ready, r_done, r_ovf;
    logic [63:0]     r_q, w_q_nxt, w_din;
    logic            w_rise, w_beat, w_full, w_pop, w_push;

    assign w_rise = ss.ss_xfer & ~r_xfer_q;
    assign w_beat = ss.ss_xfer & ss.wbs_ack & (r_state == ST_XFER);
    assign w_full = (r_cnt == CW'(DEPTH));
    assign w_pop  = ss.ss_rd_i & ~r_empty;
    assign w_push = w_beat & (~w_full | w_pop);
    assign w_din  = {ss.wbs_dat64_i, ss.wbs_dat_i};

    // Round bytes up to whole 8-byte beats; a zero count stands for 64 KiB.
    assign w_target = (ss.sg_desc == 16'd0) ? BW'(8192)
                                             : BW'((17'(ss.sg_desc) + 17'd7) >> 3);

    // Head bypass: a write landing on the next head slot is shown directly.
    always_comb begin
        w_cnt_nxt    = r_cnt + CW'(w_push) - CW'(w_pop);
        w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
        w_q_nxt      = r_mem[w_rd_ptr_nxt];
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_q_nxt = w_din;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt    = ST_XFER;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_XFER: begin
                w_beat_cnt_nxt = r_beat_cnt + BW'(w_beat);
                if (w_beat_cnt_nxt == r_target) begin
                    w_state_nxt = ST_SEGEND;
                end
            end
            ST_SEGEND: w_state_nxt = r_last ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (w_cnt_nxt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state    <= ST_IDLE;
            r_xfer_q   <= 1'b0;
            r_last     <= 1'b0;
            r_target   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_xfer_q   <= ss.ss_xfer;
            r_beat_cnt <= w_beat_cnt_nxt;
            if ((r_state == ST_IDLE) && w_rise) begin
                r_target <= w_target;
                r_last   <= ss.sg_last;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_din;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_empty  <= 1'b1;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_q      <= 64'd0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_empty  <= (w_cnt_nxt == '0);
            r_ready  <= ((CW'(DEPTH) - w_cnt_nxt) >= CW'(BURST)) && (w_state_nxt != ST_DONE);
            r_done   <= (w_state_nxt == ST_DONE);
            if (w_beat && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (w_cnt_nxt != '0) begin
                r_q <= w_q_nxt;
            end
        end
    end

    assign ss.ss_ready   = r_ready;
    assign ss.ss_done    = r_done;
    assign ss.ss_q_o     = r_q;
    assign ss.ss_empty_o = r_empty;
    assign ss.ss_cnt_o   = r_cnt;
    assign ss.ss_ovf_o   = r_ovf;

`ifdef SS_DFIFO_STAT_EN
    logic [31:0] r_beats;
    logic [15:0] r_jobs;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_beats <= 32'd0;
            r_jobs  <= 16'd0;
        end else begin
            r_beats <= r_beats + 32'(w_push);
            if (w_state_nxt == ST_DONE) begin
                r_jobs <= r_jobs + 16'd1;
            end
        end
    end

    assign ss.ss_beats_o = r_beats;
    assign ss.ss_jobs_o  = r_jobs;
`endif
endmodule

// File: tb/tb_ss_dfifo.sv
// Scoreboard bench for ss_dfifo: stimulus queues expected beats, a negedge monitor
// checks each popped head; directed checks cover reset, flow control and job end.
module tb_ss_dfifo;
    localparam int unsigned AW    = 4;
    localparam int unsigned BURST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ss_dfifo_if #(.AW(AW)) ss();

    ss_dfifo #(.AW(AW), .BURST(BURST)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .ss        (ss)
    );

    int          n_vec     = 0;
    int          n_err     = 0;
    int          done_seen = 0;
    int          exp_pushes = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count done pulses, compare every popped head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ss.ss_done) done_seen++;
            if (ss.ss_rd_i && !ss.ss_empty_o) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_unexpected: got %h expected no data", ss.ss_q_o);
                end else begin
                    check("pop_data", ss.ss_q_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seg(input logic [15:0] desc, input logic last);
        ss.sg_desc = desc;
        ss.sg_last = last;
        ss.ss_xfer = 1'b1;
        tick();
    endtask

    task automatic beat(input logic [31:0] addr, input logic expect_push);
        ss.wbs_ack     = 1'b1;
        ss.wbs_dat_i   = addr;
        ss.wbs_dat64_i = addr;
        if (expect_push) begin
            exp_q.push_back({addr, addr});
            exp_pushes++;
        end
        tick();
        ss.wbs_ack = 1'b0;
    endtask

    task automatic end_seg();
        ss.ss_xfer = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_seen < target && k < budget) begin
            tick();
            k++;
        end
        check(name, 64'(done_seen), 64'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ss.ss_ready),   64'd0);
        check({tag, "_done"},  64'(ss.ss_done),    64'd0);
        check({tag, "_empty"}, 64'(ss.ss_empty_o), 64'd1);
        check({tag, "_cnt"},   64'(ss.ss_cnt_o),   64'd0);
        check({tag, "_ovf"},   64'(ss.ss_ovf_o),   64'd0);
        check({tag, "_q"},     ss.ss_q_o,          64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        ss.ss_xfer = 1'b0; ss.sg_desc = 16'd0; ss.sg_last = 1'b0; ss.wbs_ack = 1'b0;
        ss.wbs_dat_i = 32'd0; ss.wbs_dat64_i = 32'd0; ss.ss_rd_i = 1'b0;

        // Power-on reset values, then ready rises once out of reset.
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 64'(ss.ss_ready), 64'd1);

        // Single-segment job: 128 bytes -> 16 beats, LAST set.
        base = done_seen;
        start_seg(16'h0080, 1'b1);
        for (int i = 0; i < 16; i++) begin
            beat(32'h200 + 32'(8 * i), 1'b1);
            if (i == 0) begin
                check("first_empty", 64'(ss.ss_empty_o), 64'd0);
                check("first_q", ss.ss_q_o, 64'h00000200_00000200);
            end
            if (i == 11) check("ready_at_12", 64'(ss.ss_ready), 64'd1);
            if (i == 12) begin
                check("cnt_13", 64'(ss.ss_cnt_o), 64'd13);
                check("ready_at_13", 64'(ss.ss_ready), 64'd0);
            end
        end
        end_seg();
        check("job1_full", 64'(ss.ss_cnt_o), 64'd16);
        check("job1_done_early", 64'(done_seen), 64'(base));
        ss.ss_rd_i = 1'b1;
        repeat (16) tick();
        ss.ss_rd_i = 1'b0;
        check("done_pulse", 64'(ss.ss_done), 64'd1);
        tick();
        check("done_one_cycle", 64'(ss.ss_done), 64'd0);
        check("job1_empty", 64'(ss.ss_empty_o), 64'd1);

        // Two-segment chain with continuous pops: one done only after the LAST segment.
        base = done_seen;
        ss.ss_rd_i = 1'b1;
        start_seg(16'h0080, 1'b0);
        for (int i = 0; i < 16; i++) beat(32'h1000 + 32'(8 * i), 1'b1);
        end_seg();
        repeat (4) tick();
        check("chain_no_done_seg1", 64'(done_seen), 64'(base));
        start_seg(16'h0080, 1'b1);
        for (int i = 0; i < 16; i++) beat(32'h2000 + 32'(8 * i), 1'b1);
        end_seg();
        wait_done(base + 1, 50, "chain_done");
        repeat (3) tick();
        check("chain_single_done", 64'(done_seen), 64'(base + 1));
        ss.ss_rd_i = 1'b0;
        check("chain_drained", 64'(exp_q.size()), 64'd0);

        // Odd size: 12 bytes -> 2 beats; a third acked beat is not captured.
        base = done_seen;
        start_seg(16'h000C, 1'b1);
        beat(32'h3000, 1'b1);
        beat(32'h3008, 1'b1);
        beat(32'h3010, 1'b0);
        end_seg();
        check("odd_cnt", 64'(ss.ss_cnt_o), 64'd2);
        ss.ss_rd_i = 1'b1;
        wait_done(base + 1, 20, "odd_done");
        ss.ss_rd_i = 1'b0;
        check("odd_empty", 64'(ss.ss_empty_o), 64'd1);

        // Full FIFO with simultaneous push and pop: occupancy holds, no overflow.
        base = done_seen;
        start_seg(16'h0100, 1'b1);
        for (int i = 0; i < 16; i++) beat(32'h4000 + 32'(8 * i), 1'b1);
        check("full_cnt", 64'(ss.ss_cnt_o), 64'd16);
        ss.ss_rd_i = 1'b1;
        for (int i = 16; i < 19; i++) begin
            beat(32'h4000 + 32'(8 * i), 1'b1);
            check("full_pushpop_cnt", 64'(ss.ss_cnt_o), 64'd16);
        end
        check("full_pushpop_ovf", 64'(ss.ss_ovf_o), 64'd0);
        for (int i = 19; i < 32; i++) beat(32'h4000 + 32'(8 * i), 1'b1);
        end_seg();
        wait_done(base + 1, 50, "full_done");
        ss.ss_rd_i = 1'b0;
        check("full_drained", 64'(exp_q.size()), 64'd0);
`ifdef SS_DFIFO_STAT_EN
        check("stat_beats", 64'(ss.ss_beats_o), 64'(exp_pushes));
        check("stat_jobs", 64'(ss.ss_jobs_o), 64'd4);
`endif

        // Backpressure without pops, then a 17th beat overflows.
        start_seg(16'h0100, 1'b0);
        for (int i = 0; i < 16; i++) begin
            beat(32'h5000 + 32'(8 * i), 1'b1);
            if (i == 12) check("bp_ready_13", 64'(ss.ss_ready), 64'd0);
        end
        beat(32'h5080, 1'b0);
        check("ovf_set", 64'(ss.ss_ovf_o), 64'd1);
        check("ovf_cnt", 64'(ss.ss_cnt_o), 64'd16);
        tick();
        check("ovf_sticky", 64'(ss.ss_ovf_o), 64'd1);
`ifdef SS_DFIFO_STAT_EN
        check("stat_beats_drop", 64'(ss.ss_beats_o), 64'(exp_pushes));
`endif

        // Asynchronous reset mid-cycle, mid-job: outputs clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        exp_q.delete();
        ss.ss_xfer = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst2", 64'(ss.ss_ready), 64'd1);
        check("empty_after_rst2", 64'(ss.ss_empty_o), 64'd1);
`ifdef SS_DFIFO_STAT_EN
        check("stat_beats_rst", 64'(ss.ss_beats_o), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
